pe_sequencer: RTL

PE_SEQUENCER -- requirements
Module: pe_sequencer

---
 rtl/mlp_pkg.sv | 23 ++
 rtl/pe_bank_loader.sv | 67 ++++++
 rtl/pe_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mlp_pkg.sv
// Shared types and defaults for the PE sequencer slice.
//   comp_state_e : compute-side FSM states
//   bank_t       : index of one of the two PE SRAM banks
//   bank_onehot  : bank index -> per-bank strobe vector
package mlp_pkg;

  localparam int unsigned DefaultWeightBit  = 32;
  localparam int unsigned DefaultNumAddress = 512;

  typedef logic bank_t;

  typedef enum logic [1:0] {
    C_IDLE,
    C_CLEAR,
    C_MAC,
    C_CAPTURE
  } comp_state_e;

  function automatic logic [1:0] bank_onehot(bank_t b);
    return b ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/pe_bank_loader.sv
// Weight load side of the PE sequencer: streams FAN_IN weight beats into the
// current load bank, then marks that bank full and flips to the other one.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   w_valid_i       : weight beat offered
//   full_i          : per-bank full flags (owned by the top)
//   w_ready_o       : beat accepted this cycle when w_valid_i is high
//   lb_o            : bank currently being loaded
//   write_enable_o  : per-bank write strobe (one-hot or zero)
//   load_addr_o     : write address inside the load bank
//   full_set_o      : one-cycle pulse, per bank, on the FAN_IN-th write
module pe_bank_loader
  import mlp_pkg::*;
#(
  parameter int unsigned AW     = 9,
  parameter int unsigned FAN_IN = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          w_valid_i,
  input  logic [1:0]    full_i,
  output logic          w_ready_o,
  output logic          lb_o,
  output logic [1:0]    write_enable_o,
  output logic [AW-1:0] load_addr_o,
  output logic [1:0]    full_set_o
);

  localparam logic [AW-1:0] LastIdx = AW'(FAN_IN - 1);

  bank_t         lb_q, lb_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          fire;
  logic          last;

  always_comb begin
    // Gating with the reset keeps w_ready low while the block is held in reset.
    w_ready_o      = rst_ni & ~full_i[lb_q];
    fire           = w_valid_i & w_ready_o;
    last           = (cnt_q == LastIdx);
    write_enable_o = fire ? bank_onehot(lb_q) : 2'b00;
    load_addr_o    = cnt_q;
    full_set_o     = (fire && last) ? bank_onehot(lb_q) : 2'b00;
    lb_o           = lb_q;

    cnt_d = cnt_q;
    lb_d  = lb_q;
    if (fire) begin
      if (last) begin
        cnt_d = '0;
        lb_d  = ~lb_q;
      end else begin
        cnt_d = cnt_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lb_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      lb_q  <= lb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pe_sequencer.sv
// Double-buffered sequencer for one PE: weights stream into one SRAM bank
// while the other bank is read out against incoming activations. Each full
// bank produces one neuron result on the r_* handshake.
//   clk, reset        : clock, asynchronous active-low reset
//   w_valid/ready/data: weight beats (FAN_IN per neuron)
//   x_valid/ready/data: activation beats (FAN_IN per neuron)
//   pe_*              : bank select, strobes, addresses and data to the PE
//   pe_out            : PE accumulator result
//   r_valid/ready/data: captured neuron result
module pe_sequencer
  import mlp_pkg::*;
#(
  parameter int unsigned WEIGHT_BIT  = DefaultWeightBit,
  parameter int unsigned NUM_ADDRESS = DefaultNumAddress,
  parameter int unsigned FAN_IN      = 16,
  localparam int unsigned AW         = $clog2(NUM_ADDRESS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [WEIGHT_BIT-1:0] w_data,
  input  logic                  x_valid,
  output logic                  x_ready,
  input  logic [WEIGHT_BIT-1:0] x_data,
  output logic                  pe_demux_select,
  output logic                  pe_mux_select,
  output logic [1:0]            pe_write_enable,
  output logic                  pe_read_enable,
  output logic [AW-1:0]         pe_address0,
  output logic [AW-1:0]         pe_address1,
  output logic [WEIGHT_BIT-1:0] pe_weight,
  output logic [WEIGHT_BIT-1:0] pe_input_data,
  output logic                  pe_reset,
  input  logic [WEIGHT_BIT-1:0] pe_out,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [WEIGHT_BIT-1:0] r_data
);

  localparam logic [AW-1:0] LastIdx = AW'(FAN_IN - 1);

  comp_state_e           state_q, state_d;
  bank_t                 cb_q, cb_d;
  logic [1:0]            full_q, full_d;
  logic [1:0]            full_set, full_clr;
  logic [AW-1:0]         x_cnt_q, x_cnt_d;
  logic [AW-1:0]         x_idx_q, x_idx_d;
  logic                  r_valid_q, r_valid_d;
  logic [WEIGHT_BIT-1:0] r_data_q, r_data_d;
  logic [AW-1:0]         addr0_q, addr1_q;
  logic [AW-1:0]         load_addr;
  logic [AW-1:0]         rd_addr;
  logic                  lb;

  pe_bank_loader #(
    .AW     (AW),
    .FAN_IN (FAN_IN)
  ) u_loader (
    .clk_i          (clk),
    .rst_ni         (reset),
    .w_valid_i      (w_valid),
    .full_i         (full_q),
    .w_ready_o      (w_ready),
    .lb_o           (lb),
    .write_enable_o (pe_write_enable),
    .load_addr_o    (load_addr),
    .full_set_o     (full_set)
  );

  assign pe_demux_select = lb;
  assign pe_weight       = w_data;
  assign pe_mux_select   = cb_q;
  assign r_valid         = r_valid_q;
  assign r_data          = r_data_q;

  // Compute FSM: next state and outputs.
  always_comb begin
    state_d        = state_q;
    cb_d           = cb_q;
    x_cnt_d        = x_cnt_q;
    x_idx_d        = x_idx_q;
    r_valid_d      = r_valid_q;
    r_data_d       = r_data_q;
    full_clr       = 2'b00;
    x_ready        = 1'b0;
    pe_reset       = ~reset;
    pe_input_data  = '0;
    pe_read_enable = 1'b0;
    rd_addr        = x_idx_q;

    if (r_valid_q && r_ready) begin
      r_valid_d = 1'b0;
    end

    unique case (state_q)
      C_IDLE: begin
        if (full_q[cb_q] && !r_valid_q) begin
          state_d = C_CLEAR;
        end
      end
      C_CLEAR: begin
        pe_reset = 1'b1;
        x_cnt_d  = '0;
        x_idx_d  = '0;
        state_d  = C_MAC;
      end
      C_MAC: begin
        x_ready        = 1'b1;
        pe_read_enable = 1'b1;
        // Idle cycles feed zero so the accumulator is unaffected by bubbles.
        if (x_valid) begin
          pe_input_data = x_data;
          rd_addr       = x_cnt_q;
          x_idx_d       = x_cnt_q;
          if (x_cnt_q == LastIdx) begin
            x_cnt_d = '0;
            state_d = C_CAPTURE;
          end else begin
            x_cnt_d = x_cnt_q + AW'(1);
          end
        end
      end
      C_CAPTURE: begin
        pe_read_enable = 1'b1;
        r_data_d       = pe_out;
        r_valid_d      = 1'b1;
        full_clr       = bank_onehot(cb_q);
        cb_d           = ~cb_q;
        state_d        = C_IDLE;
      end
      default: state_d = C_IDLE;
    endcase

    // Set and clear always target different banks, so both apply together.
    full_d = (full_q & ~full_clr) | full_set;
  end

  // Address ports: writer or reader of that bank drives it, otherwise hold.
  always_comb begin
    pe_address0 = addr0_q;
    pe_address1 = addr1_q;
    if (pe_write_enable[0]) begin
      pe_address0 = load_addr;
    end else if (pe_read_enable && (cb_q == 1'b0)) begin
      pe_address0 = rd_addr;
    end
    if (pe_write_enable[1]) begin
      pe_address1 = load_addr;
    end else if (pe_read_enable && (cb_q == 1'b1)) begin
      pe_address1 = rd_addr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= C_IDLE;
      cb_q      <= 1'b0;
      full_q    <= 2'b00;
      x_cnt_q   <= '0;
      x_idx_q   <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      addr0_q   <= '0;
      addr1_q   <= '0;
    end else begin
      state_q   <= state_d;
      cb_q      <= cb_d;
      full_q    <= full_d;
      x_cnt_q   <= x_cnt_d;
      x_idx_q   <= x_idx_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      addr0_q   <= pe_address0;
      addr1_q   <= pe_address1;
    end
  end

endmodule
